// File: rtl/his_peak_reader.sv
// Scans each pixel's histogram through SRAM port b and reports the bin with the
// highest count per pixel over a valid/ready handshake.
`ifndef Np
`define Np 3
`endif
`ifndef peakMax
`define peakMax 8
`endif
`ifndef PIXEL_NUM_PER_RAM
`define PIXEL_NUM_PER_RAM 2
`endif
`ifndef RAM_ADDR
`define RAM_ADDR 4
`endif

module his_peak_reader #(
  parameter int BIN_NUM_PER_HIS   = 2**`Np,
  parameter int PIXEL_NUM_PER_RAM = `PIXEL_NUM_PER_RAM,
  parameter int PIX_W             = 4,
  parameter int RAM_ADDR          = `RAM_ADDR
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic [`peakMax-1:0] counts,
  output logic [RAM_ADDR-1:0] raddr,
  output logic                rEnable,
  output logic                readFlag,
  output logic                busy,
  output logic                peakValid,
  input  logic                peakReady,
  output logic [PIX_W-1:0]    peakPixel,
  output logic [`Np-1:0]      peakBin,
  output logic [`peakMax-1:0] peakValue,
  output logic                done
);

  localparam int BIN_W = `Np;
  localparam int CNT_W = `peakMax;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM_PER_HIS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_e;

  // Strict compare keeps the lowest bin on ties; the first bin always loads.
  function automatic logic beats_max(input logic first,
                                     input logic [CNT_W-1:0] cand,
                                     input logic [CNT_W-1:0] cur);
    return first || (cand > cur);
  endfunction

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pixel_q, pixel_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               vld_p1_q, vld_p1_d;
  logic               first_p1_q, first_p1_d;
  logic [BIN_W-1:0]   bin_p1_q, bin_p1_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [BIN_W-1:0]   idx_q, idx_d;

  always_comb begin
    state_d    = state_q;
    pixel_d    = pixel_q;
    bin_d      = bin_q;
    // p0 -> p1: remember which bin was issued so its data can be judged next cycle
    vld_p1_d   = (state_q == S_READ);
    first_p1_d = (bin_q == '0);
    bin_p1_d   = bin_q;
    max_d      = max_q;
    idx_d      = idx_q;

    // p1: read data for the bin issued last cycle is on counts now
    if (vld_p1_q && beats_max(first_p1_q, counts, max_q)) begin
      max_d = counts;
      idx_d = bin_p1_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          pixel_d = '0;
          bin_d   = '0;
        end
      end
      S_READ: begin
        if (bin_q == LAST_BIN) begin
          state_d = S_DRAIN;
          bin_d   = '0;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (peakReady) begin
          if (pixel_q < LAST_PIX) begin
            state_d = S_READ;
            pixel_d = pixel_q + 1'b1;
            bin_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pixel_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      pixel_q    <= '0;
      bin_q      <= '0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      bin_p1_q   <= '0;
      max_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pixel_q    <= pixel_d;
      bin_q      <= bin_d;
      vld_p1_q   <= vld_p1_d;
      first_p1_q <= first_p1_d;
      bin_p1_q   <= bin_p1_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
    end
  end

  assign raddr     = RAM_ADDR'(pixel_q) * RAM_ADDR'(BIN_NUM_PER_HIS) + RAM_ADDR'(bin_q);
  assign readFlag  = (state_q == S_READ);
  assign rEnable   = ~readFlag;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_OUT);
  assign peakValid = (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign peakPixel = pixel_q;
  assign peakBin   = idx_q;
  assign peakValue = max_q;

endmodule

// File: doc/his_peak_reader.md
HIS_PEAK_READER -- requirements
Module: his_peak_reader

Interface
REQ-001 Parameters: BIN_NUM_PER_HIS (bins per histogram, default 2**`Np), PIXEL_NUM_PER_RAM (pixels per SRAM, default `PIXEL_NUM_PER_RAM), PIX_W (pixel index width, default 4), RAM_ADDR (SRAM address width, default `RAM_ADDR).
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 res  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to scan all pixels; honoured only in IDLE.
REQ-005 counts  input  `peakMax  SRAM port-b read data; valid one cycle after the address is presented.
REQ-006 raddr  output  RAM_ADDR  SRAM port-b address (addrb).
REQ-007 rEnable  output  1  port-b read enable, active-low (0 = read).
REQ-008 readFlag  output  1  port-b memory enable (meb), active-high.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 peakValid  output  1  peak result for one pixel is presented.
REQ-011 peakReady  input  1  consumer accepts the result when high together with peakValid.
REQ-012 peakPixel  output  PIX_W  pixel index of the presented result.
REQ-013 peakBin  output  `Np  bin index of the maximum count.
REQ-014 peakValue  output  `peakMax  maximum count value.
REQ-015 done  output  1  one-cycle pulse after the last pixel's result is accepted.

Function
REQ-016 States: IDLE, READ, DRAIN, OUT, DONE.
REQ-017 IDLE: readFlag=0, rEnable=1, busy=0, peakValid=0; start=1 -> READ with pixel=0, bin=0.
REQ-018 Address rule: raddr = pixel*BIN_NUM_PER_HIS + bin, computed at RAM_ADDR width.
REQ-019 READ: readFlag=1, rEnable=0; one new address per cycle, bin incremented each cycle.
REQ-020 READ -> DRAIN in the cycle after bin BIN_NUM_PER_HIS-1 is issued; DRAIN samples the final counts, readFlag=0, rEnable=1.
REQ-021 Compare: counts for bin k are sampled one cycle after issue; bin 0 unconditionally loads max/index; later bins replace only when counts > current max (strict), so ties keep the lowest bin.
REQ-022 DRAIN -> OUT after one cycle; OUT drives peakValid=1 with peakPixel/peakBin/peakValue stable until accepted.
REQ-023 Backpressure: no SRAM reads are issued in OUT; peakValid is held and outputs do not change while peakReady=0.
REQ-024 OUT with peakReady=1: if pixel < PIXEL_NUM_PER_RAM-1 -> READ with pixel+1, bin=0, peakValid=0 in the next cycle; otherwise -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-026 start received outside IDLE is ignored and has no effect.
REQ-027 All-zero histogram: peakBin=0, peakValue=0.
REQ-028 Counts of all ones (2**`peakMax-1) are compared without overflow; no saturation or wrap is applied.
REQ-029 Latency per pixel with peakReady held at 1: BIN_NUM_PER_HIS+2 cycles from the first read to peakValid.
REQ-030 The block never writes the SRAM; port a is not driven by this block.

Reset
REQ-031 res=1 at any clock edge -> IDLE next cycle; raddr=0, rEnable=1, readFlag=0, busy=0, peakValid=0, peakPixel=0, peakBin=0, peakValue=0, done=0; the running max is cleared.
REQ-032 Reset mid-scan abandons the scan; no partial result and no done pulse is emitted; a new start is required.
REQ-033 res has priority over start in the same cycle.

Verification
REQ-034 BIN_NUM_PER_HIS=8, PIXEL_NUM_PER_RAM=2; pixel0 counts {1,5,3,9,2,0,9,4}, pixel1 all 0, peakReady=1 -> results (0,3,9) and (1,0,0), then a done pulse; raddr sequence 0..7, 8..15.
REQ-035 Single-cycle SRAM model with a peak at bin 7 (last bin) of value 2**`peakMax-1 -> peakBin=7, peakValue=all ones; peakValid asserted 10 cycles after the first read.
REQ-036 peakReady held 0 for 5 cycles in OUT -> peakValid and outputs stable, readFlag=0 throughout; pixel 1 reads start the cycle after peakReady=1.
REQ-037 start pulsed again during READ -> ignored; exactly PIXEL_NUM_PER_RAM results and one done pulse.
REQ-038 res=1 at bin 4 of pixel 1 -> all outputs at reset values next cycle, no done; a new start rescans from raddr=0.
REQ-039 Ties at bins 2 and 5 (value 6, all other bins lower) -> peakBin=2.
